// File: rtl/ofdm_pilot_mapper_if.sv
// Stream and control bundle between the pilot mapper and its neighbours.
// The slave side is the mapper; the master side feeds data and drains symbols.
interface ofdm_pilot_mapper_if #(
    parameter int Q = 16
);
    logic                frame_start;
    logic [7:0]          n_sym;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic signed [Q-1:0] in_re;
    logic signed [Q-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [Q-1:0] out_re;
    logic signed [Q-1:0] out_im;
    logic [5:0]          out_idx;
    logic                out_sos;
    logic                out_sof;

    modport slave (
        input  frame_start, n_sym, in_valid, in_re, in_im, out_ready,
        output busy, in_ready, out_valid, out_re, out_im, out_idx, out_sos, out_sof
    );

    modport master (
        output frame_start, n_sym, in_valid, in_re, in_im, out_ready,
        input  busy, in_ready, out_valid, out_re, out_im, out_idx, out_sos, out_sof
    );
endinterface

// File: rtl/ofdm_pilot_mapper.sv
// Builds 64-bin OFDM symbols for the transmit IFFT: training symbols, then data
// symbols with LFSR-signed BPSK pilots and nulled DC/guard bins.
module ofdm_pilot_mapper #(
    parameter int          N_PRE    = 2,
    parameter int          Q_int    = 7,
    parameter int          Q_dec    = 9,
    parameter logic [63:0] PRE_SIGN = 64'h0
) (
    input logic                clk,
    input logic                rst,
    ofdm_pilot_mapper_if.slave bus
);
    localparam int Q     = Q_int + Q_dec;
    localparam int ONE_I = 1 << Q_dec;
    localparam logic signed [Q-1:0] ONE_P = ONE_I[Q-1:0];
    localparam logic signed [Q-1:0] ONE_N = -ONE_P;

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t              state_q, state_d;
    logic [5:0]          k_q, k_d;
    logic [7:0]          sym_q, sym_d;
    logic [7:0]          n_sym_q, n_sym_d;
    logic [6:0]          lfsr_q, lfsr_d;
    logic                pol_q, pol_d;
    logic                out_valid_q, out_valid_d;
    logic signed [Q-1:0] out_re_q, out_re_d;
    logic signed [Q-1:0] out_im_q, out_im_d;
    logic [5:0]          out_idx_q, out_idx_d;
    logic                out_sos_q, out_sos_d;
    logic                out_sof_q, out_sof_d;

    logic [63:0]         null_mask;
    logic [63:0]         pilot_mask;
    logic                is_null, is_pilot, is_data;
    logic                adv, avail, load, fb;
    logic signed [Q-1:0] smp_re, smp_im;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_bin
            assign null_mask[gi]  = (gi == 0) || (gi >= 27 && gi <= 37);
            assign pilot_mask[gi] = (gi == 7) || (gi == 21) || (gi == 43) || (gi == 57);
        end
    endgenerate

    assign is_null  = null_mask[k_q];
    assign is_pilot = pilot_mask[k_q];
    assign is_data  = !is_null && !is_pilot;

    // A data bin only has a sample when upstream offers one; everything else is self-generated.
    assign adv   = !out_valid_q || bus.out_ready;
    assign avail = (state_q == PRE) || ((state_q == DATA) && (!is_data || bus.in_valid));
    assign load  = adv && avail;
    assign fb    = lfsr_q[6] ^ lfsr_q[3];

    assign bus.in_ready  = (state_q == DATA) && is_data && adv;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_sos   = out_sos_q;
    assign bus.out_sof   = out_sof_q;

    always_comb begin
        smp_re = '0;
        smp_im = '0;
        if (state_q == PRE && !is_null) begin
            smp_re = PRE_SIGN[k_q] ? ONE_N : ONE_P;
        end else if (state_q == DATA && is_data) begin
            smp_re = bus.in_re;
            smp_im = bus.in_im;
        end else if (state_q == DATA && is_pilot) begin
            // Bin 57 carries base -1, so its sign is the inverse of the symbol polarity.
            smp_re = (pol_q ^ (k_q == 6'd57)) ? ONE_N : ONE_P;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        sym_d       = sym_q;
        n_sym_d     = n_sym_q;
        lfsr_d      = lfsr_q;
        pol_d       = pol_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        out_sos_d   = out_sos_q;
        out_sof_d   = out_sof_q;

        if (adv) out_valid_d = load;

        if (load) begin
            out_re_d  = smp_re;
            out_im_d  = smp_im;
            out_idx_d = k_q;
            out_sos_d = (k_q == 6'd0);
            out_sof_d = (state_q == PRE) && (sym_q == 8'd0) && (k_q == 6'd0);
            k_d       = k_q + 6'd1;
            if (state_q == DATA && k_q == 6'd0) begin
                lfsr_d = {lfsr_q[5:0], fb};
                pol_d  = fb;
            end
            if (k_q == 6'd63) begin
                sym_d = sym_q + 8'd1;
                if (state_q == PRE && sym_q == 8'(N_PRE - 1)) begin
                    sym_d   = 8'd0;
                    state_d = (n_sym_q != 8'd0) ? DATA : IDLE;
                end else if (state_q == DATA && sym_q == n_sym_q - 8'd1) begin
                    sym_d   = 8'd0;
                    state_d = IDLE;
                end
            end
        end

        if (state_q == IDLE && bus.frame_start) begin
            state_d = PRE;
            n_sym_d = bus.n_sym;
            k_d     = 6'd0;
            sym_d   = 8'd0;
            lfsr_d  = 7'h7F;
            pol_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= 6'd0;
            sym_q       <= 8'd0;
            n_sym_q     <= 8'd0;
            lfsr_q      <= 7'h7F;
            pol_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= 6'd0;
            out_sos_q   <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sym_q       <= sym_d;
            n_sym_q     <= n_sym_d;
            lfsr_q      <= lfsr_d;
            pol_q       <= pol_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_sos_q   <= out_sos_d;
            out_sof_q   <= out_sof_d;
        end
    end
endmodule

// File: tb/tb_ofdm_pilot_mapper.sv
// Scoreboard bench for ofdm_pilot_mapper: a frame model fills the expected queue
// at frame_start and every accepted output sample is popped and compared.
module tb_ofdm_pilot_mapper;
    localparam int Q     = 16;
    localparam int N_PRE = 2;
    localparam logic [63:0] PRE_SIGN = 64'h1;
    localparam logic signed [Q-1:0] P512 = 16'sd512;
    localparam logic signed [Q-1:0] M512 = -16'sd512;

    typedef struct packed {
        logic signed [Q-1:0] re;
        logic signed [Q-1:0] im;
        logic [5:0]          idx;
        logic                sos;
        logic                sof;
        logic                dat;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ofdm_pilot_mapper_if #(.Q(Q)) bus_if();

    ofdm_pilot_mapper #(
        .N_PRE(N_PRE), .Q_int(7), .Q_dec(9), .PRE_SIGN(PRE_SIGN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    smp_t exp_q[$];
    logic signed [Q-1:0] p7[$];
    logic signed [Q-1:0] p57[$];
    int   src_idx = 0;
    bit   rand_rdy = 0;
    bit   im_mode = 0;
    bit   mon_en = 0;
    int   gap_at = -1;
    int   gap_left = 0;
    bit   fs_req = 0;
    logic [7:0] fs_nsym = 8'd0;
    bit   rst_req = 0;
    int   n_out, n_sof, n_sos;
    int   cyc = 0;
    int   first_cyc, last_cyc;
    bit   hold_v = 0;
    smp_t hold_s;

    // Reference frame: training symbols then data symbols, pilots signed by the LFSR.
    function automatic void push_frame(int nsym);
        logic [6:0] s = 7'h7F;
        logic pol = 1'b0;
        int   v = 1;
        bit   nul, pil;
        smp_t e;
        for (int f = 0; f < N_PRE + nsym; f++) begin
            if (f >= N_PRE) begin
                pol = s[6] ^ s[3];
                s   = {s[5:0], pol};
            end
            for (int k = 0; k < 64; k++) begin
                e     = '0;
                e.idx = 6'(k);
                e.sos = (k == 0);
                e.sof = (f == 0) && (k == 0);
                nul   = (k == 0) || (k >= 27 && k <= 37);
                pil   = (k == 7) || (k == 21) || (k == 43) || (k == 57);
                if (f < N_PRE) begin
                    if (!nul) e.re = PRE_SIGN[k] ? M512 : P512;
                end else if (pil) begin
                    e.re = ((k == 57) ^ pol) ? M512 : P512;
                end else if (!nul) begin
                    e.re  = 16'(v);
                    e.im  = im_mode ? 16'(-v) : 16'sd0;
                    e.dat = 1'b1;
                    v++;
                end
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void start_frame(int nsym);
        push_frame(nsym);
        fs_req    = 1'b1;
        fs_nsym   = 8'(nsym);
        src_idx   = 0;
        n_out     = 0;
        n_sof     = 0;
        n_sos     = 0;
        first_cyc = 0;
        last_cyc  = 0;
        p7.delete();
        p57.delete();
    endfunction

    task automatic cycle();
        smp_t e;
        bit   nxt_dat;
        bit   exp_rdy;
        @(negedge clk);
        cyc++;
        rst                = rst_req;
        rst_req            = 1'b0;
        bus_if.out_ready   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus_if.frame_start = fs_req;
        bus_if.n_sym       = fs_nsym;
        fs_req             = 1'b0;
        if (gap_left > 0 && src_idx == gap_at) begin
            bus_if.in_valid = 1'b0;
            gap_left--;
        end else begin
            bus_if.in_valid = 1'b1;
        end
        bus_if.in_re = 16'(src_idx + 1);
        bus_if.in_im = im_mode ? 16'(-(src_idx + 1)) : 16'sd0;
        #1;
        if (mon_en) begin
            if (hold_v) begin
                checks++;
                if (bus_if.out_valid !== 1'b1 || bus_if.out_re !== hold_s.re || bus_if.out_im !== hold_s.im ||
                    bus_if.out_idx !== hold_s.idx || bus_if.out_sos !== hold_s.sos || bus_if.out_sof !== hold_s.sof) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b re=%0d im=%0d idx=%0d, want v=1 re=%0d im=%0d idx=%0d",
                             bus_if.out_valid, bus_if.out_re, bus_if.out_im, bus_if.out_idx, hold_s.re, hold_s.im, hold_s.idx);
                end
            end
            nxt_dat = 1'b0;
            if (bus_if.out_valid === 1'b1) begin
                if (exp_q.size() > 1) nxt_dat = exp_q[1].dat;
            end else if (exp_q.size() > 0) begin
                nxt_dat = exp_q[0].dat;
            end
            exp_rdy = nxt_dat && (bus_if.out_valid !== 1'b1 || bus_if.out_ready);
            checks++;
            if (bus_if.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %0b, want %0b (cycle %0d)", bus_if.in_ready, exp_rdy, cyc);
            end
            if (bus_if.out_valid === 1'b1 && bus_if.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_sample: got idx=%0d re=%0d, want no sample", bus_if.out_idx, bus_if.out_re);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_if.out_re !== e.re || bus_if.out_im !== e.im || bus_if.out_idx !== e.idx ||
                        bus_if.out_sos !== e.sos || bus_if.out_sof !== e.sof) begin
                        errors++;
                        $display("FAIL sample: got re=%0d im=%0d idx=%0d sos=%0b sof=%0b, want re=%0d im=%0d idx=%0d sos=%0b sof=%0b",
                                 bus_if.out_re, bus_if.out_im, bus_if.out_idx, bus_if.out_sos, bus_if.out_sof,
                                 e.re, e.im, e.idx, e.sos, e.sof);
                    end
                end
                $display("out cyc=%0d idx=%0d re=%0d im=%0d sos=%0b sof=%0b", cyc, bus_if.out_idx,
                         bus_if.out_re, bus_if.out_im, bus_if.out_sos, bus_if.out_sof);
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
                if (bus_if.out_sof) n_sof++;
                if (bus_if.out_sos) n_sos++;
                if (bus_if.out_idx == 6'd7)  p7.push_back(bus_if.out_re);
                if (bus_if.out_idx == 6'd57) p57.push_back(bus_if.out_re);
            end
            hold_v = (bus_if.out_valid === 1'b1) && !bus_if.out_ready;
            hold_s = '{re: bus_if.out_re, im: bus_if.out_im, idx: bus_if.out_idx,
                       sos: bus_if.out_sos, sof: bus_if.out_sof, dat: 1'b0};
        end
        if (bus_if.in_valid && bus_if.in_ready === 1'b1) src_idx++;
    endtask

    task automatic run_until_done(string name);
        int n = 0;
        while (!(exp_q.size() == 0 && bus_if.busy === 1'b0 && bus_if.out_valid === 1'b0) && n < 4000) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d samples outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            rst_req = 1'b1;
            cycle();
        end
        cycle();
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0b busy=%0b in_ready=%0b, want 0 0 0",
                     bus_if.out_valid, bus_if.busy, bus_if.in_ready);
        end
        checks++;
        if (bus_if.out_re !== 16'sd0 || bus_if.out_im !== 16'sd0 || bus_if.out_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_data: got re=%0d im=%0d idx=%0d, want 0 0 0",
                     bus_if.out_re, bus_if.out_im, bus_if.out_idx);
        end
        checks++;
        if (bus_if.out_sos !== 1'b0 || bus_if.out_sof !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got sos=%0b sof=%0b, want 0 0", bus_if.out_sos, bus_if.out_sof);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_training();
        start_frame(0);
        cycle();
        cycle();
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_t1: got busy=%0b valid=%0b, want 1 0", bus_if.busy, bus_if.out_valid);
        end
        cycle();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_sos !== 1'b1 || bus_if.out_sof !== 1'b1) begin
            errors++;
            $display("FAIL start_t2: got valid=%0b sos=%0b sof=%0b, want 1 1 1",
                     bus_if.out_valid, bus_if.out_sos, bus_if.out_sof);
        end
        run_until_done("training");
        checks++;
        if (n_out != 128 || n_sof != 1 || n_sos != 2) begin
            errors++;
            $display("FAIL training_count: got n=%0d sof=%0d sos=%0d, want 128 1 2", n_out, n_sof, n_sos);
        end
    endtask

    task automatic test_ramp();
        logic signed [Q-1:0] want7;
        start_frame(5);
        run_until_done("ramp");
        checks++;
        if (n_out != 448 || last_cyc - first_cyc + 1 != 448) begin
            errors++;
            $display("FAIL ramp_rate: got n=%0d span=%0d, want 448 448", n_out, last_cyc - first_cyc + 1);
        end
        for (int s = 0; s < 5; s++) begin
            want7 = (s == 4) ? M512 : P512;
            checks++;
            if (p7.size() < N_PRE + 5 || p57.size() < N_PRE + 5) begin
                errors++;
                $display("FAIL pilot_sym%0d: got %0d pilot samples, want %0d", s, p7.size(), N_PRE + 5);
            end else if (p7[N_PRE + s] !== want7 || p57[N_PRE + s] !== -want7) begin
                errors++;
                $display("FAIL pilot_sym%0d: got k7=%0d k57=%0d, want %0d %0d",
                         s, p7[N_PRE + s], p57[N_PRE + s], want7, -want7);
            end
        end
    endtask

    task automatic test_random_ready();
        rand_rdy = 1'b1;
        im_mode  = 1'b1;
        start_frame(3);
        run_until_done("random_ready");
        checks++;
        if (n_out != 320) begin
            errors++;
            $display("FAIL random_count: got %0d, want 320", n_out);
        end
        rand_rdy = 1'b0;
        im_mode  = 1'b0;
    endtask

    task automatic test_starve();
        gap_at   = 5;
        gap_left = 3;
        start_frame(2);
        run_until_done("starve");
        checks++;
        if (n_out != 256 || last_cyc - first_cyc + 1 != 259) begin
            errors++;
            $display("FAIL starve_gap: got n=%0d span=%0d, want 256 259", n_out, last_cyc - first_cyc + 1);
        end
        gap_at = -1;
    endtask

    task automatic test_busy_start();
        start_frame(1);
        repeat (100) cycle();
        fs_req  = 1'b1;
        fs_nsym = 8'd4;
        run_until_done("busy_start");
        repeat (10) cycle();
        checks++;
        if (n_out != 192 || bus_if.busy !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: got n=%0d busy=%0b valid=%0b, want 192 0 0",
                     n_out, bus_if.busy, bus_if.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        start_frame(3);
        while (n_out < 212 && n < 2000) begin
            cycle();
            n++;
        end
        rst_req = 1'b1;
        cycle();
        exp_q.delete();
        hold_v = 1'b0;
        cycle();
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%0b busy=%0b, want 0 0", bus_if.out_valid, bus_if.busy);
        end
        start_frame(1);
        run_until_done("after_reset");
        checks++;
        if (n_out != 192 || p7.size() != N_PRE + 1 || p7[N_PRE] !== P512) begin
            errors++;
            $display("FAIL reset_restart: got n=%0d pilots=%0d, want 192 %0d with first data pilot 512",
                     n_out, p7.size(), N_PRE + 1);
        end
    endtask

    initial begin
        bus_if.frame_start = 1'b0;
        bus_if.n_sym       = 8'd0;
        bus_if.in_valid    = 1'b0;
        bus_if.in_re       = '0;
        bus_if.in_im       = '0;
        bus_if.out_ready   = 1'b1;
        test_reset();
        test_training();
        test_ramp();
        test_random_ready();
        test_starve();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofdm_pilot_mapper.md
# ofdm_pilot_mapper

Transmit-side subcarrier mapper for the OFDM chain: it builds each 64-point frequency-domain symbol that feeds the transmit IFFT. For every frame it emits N_PRE known training symbols, then n_sym data symbols. Each data symbol carries 48 data subcarriers taken from the input stream, 4 BPSK pilots with LFSR-driven polarity, and the nulled DC and guard carriers. The training and pilot values are the exact references the receiver's channel-estimation multiplier conjugates against, so their values and ordering are normative.

## Interface
- N, 64, subcarriers per symbol (fixed; index width 6)
- N_PRE, 2, training symbols per frame
- Q_int, 7, integer bits of sample format
- Q_dec, 9, fractional bits; +1.0 = 2^Q_dec = 512
- Q, Q_int+Q_dec, sample width (16)
- PRE_SIGN, 64'h0, training sign mask; bit k=1 gives -1.0 on subcarrier k, else +1.0
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; starts a frame; sampled only in IDLE
- n_sym  in  8  data-symbol count, captured with frame_start
- in_valid  in  1  data sample valid
- in_ready  out  1  data sample accepted when in_valid & in_ready
- in_re, in_im  in  Q  signed data subcarrier value
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream (IFFT) accepts when out_valid & out_ready
- out_re, out_im  out  Q  signed subcarrier value
- out_idx  out  6  subcarrier index 0..63 (FFT bin order)
- out_sos  out  1  high with out_idx=0 of every symbol
- out_sof  out  1  high with the first sample of the frame only
- busy  out  1  state != IDLE

## Operation
- Subcarrier classes, by bin index k:
  - null: k=0 and k=27..37
  - pilot: k=7, 21, 43, 57
  - data: all other k (48 bins)
- FSM states: IDLE, PRE, DATA.
  - IDLE -> PRE on frame_start. Capture n_sym, clear counters, seed the LFSR to 7'h7F.
  - PRE emits N_PRE*64 samples and consumes no input. Null bins are 0. Other bins are ±512 real with imaginary 0, signed by PRE_SIGN[k].
  - After the last PRE sample: go to DATA if n_sym != 0, else to IDLE.
  - DATA emits n_sym symbols, then returns to IDLE.
- Data bins: out = (in_re, in_im), passed through unmodified, in ascending k.
- Null bins: out = (0, 0).
- Pilot bins: real = base*pol*512, imaginary = 0.
  - base = +1 at k=7, 21, 43; base = -1 at k=57.
  - pol = +1 if the LFSR output bit is 0, -1 if it is 1.
- LFSR: state s[6:0], fb = s[6]^s[3], s <= {s[5:0], fb}.
  - Steps exactly once per data symbol, at that symbol's k=0.
  - fb is held as the polarity for the whole symbol.
  - From seed 7'h7F the first five polarities are +1, +1, +1, +1, -1.
- Output stage: a single register. Define adv = !out_valid | out_ready.
  - The register loads a new sample only when adv holds and a sample is available.
  - In PRE, and on null/pilot bins in DATA, a sample is always available.
  - On data bins, a sample is available only when in_valid is high.
- in_ready = (state==DATA) & data-bin(k) & adv. It is combinational from state, counter and out_ready; it is never asserted on pilot or null bins.
- With out_valid=1 and out_ready=0, out_* hold stable; counters and LFSR do not move.
- Input starvation on a data bin: emit nothing, hold k, set out_valid=0 once the current sample is taken. Pilot/null bins are never skipped or reordered.
- frame_start while busy is ignored; the in-flight frame is unaffected.
- rst at any point: state IDLE, counters 0, LFSR 7'h7F, out_valid=0. The partial frame is discarded.
- Arithmetic: no saturation or scaling. Pilot and training constants are exact ±512 in Q-bit two's complement.

## Timing
- Reset values: out_valid 0, out_re/out_im 0, out_idx 0, out_sos 0, out_sof 0, busy 0, in_ready 0.
- frame_start in cycle t: busy=1 at t+1. The first sample (k=0, out_sos=out_sof=1) is valid at t+2.
- Latency from an accepted input sample to the output register: 1 cycle.
- Sustained rate with out_ready=1 and in_valid=1: one sample per cycle.
  - A frame therefore occupies exactly (N_PRE+n_sym)*64 consecutive valid cycles.
- busy falls in the cycle after the final sample is loaded into the output register. That final sample may still be waiting on out_ready.
- A new frame_start is accepted once busy=0, even while the last sample is still pending. The new frame's first sample loads only after the pending one is taken.

## Test plan
- Reset mid-DATA (rst high 1 cycle at symbol 1, k=20) -> next cycle out_valid=0, busy=0. The next frame restarts with pilot polarity +1.
- frame_start, n_sym=0, PRE_SIGN=64'h1, out_ready=1 -> exactly 128 samples, then idle.
  - k=0 outputs 0 (null); k=1 outputs +512; k=27..37 output 0.
  - out_sof pulses once, out_sos twice.
- n_sym=5, input ramp in_re=1,2,3…, in_im=0 -> data bins carry 1..48 per symbol in ascending k.
  - k=7 pilot = +512, +512, +512, +512, -512 across symbols 0..4.
  - k=57 pilot is the negation of k=7.
- Random out_ready with probability 0.5 -> output sequence identical to the out_ready=1 run; out_* stable whenever valid & !ready.
- in_valid low for 3 cycles at DATA symbol 0, k=6 -> no output during the gap; in_ready=0 throughout k=7. Sequence resumes without loss.
- frame_start pulsed mid-frame -> ignored. Total sample count equals the first frame's (N_PRE+n_sym)*64.
